ysyx_24100005_lsu: RTL and testbench
====================================

YSYX_24100005_LSU -- requirements
Module: ysyx_24100005_lsu

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning address width in bits.
REQ-002 SHALL have parameter DATA_W, default 32, meaning data bus width; legal values are 32 and 64.
REQ-003 SHALL have parameter TIMEOUT, default 255, meaning the maximum number of cycles waited for mem_rvalid; legal range is 1..65535.
REQ-004 SHALL have port clk  in  1  clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  in  1  reset; asynchronous, active-low.
REQ-006 SHALL have port req_valid  in  1  core request valid.
REQ-007 SHALL have port req_ready  out  1  LSU can accept a request.
REQ-008 SHALL have port req_wen  in  1  1=store, 0=load.
REQ-009 SHALL have port req_funct3  in  3  RISC-V funct3 size and sign code.
REQ-010 SHALL have port req_addr  in  ADDR_W  byte address.
REQ-011 SHALL have port req_wdata  in  DATA_W  store data, right-aligned.
REQ-012 SHALL have port resp_valid  out  1  response valid.
REQ-013 SHALL have port resp_ready  in  1  core accepts the response.
REQ-014 SHALL have port resp_rdata  out  DATA_W  extended load data.
REQ-015 SHALL have port resp_err  out  1  misaligned, illegal or timeout.
REQ-016 SHALL have port mem_valid  out  1  memory request valid.
REQ-017 SHALL have port mem_ready  in  1  memory accepts the request.
REQ-018 SHALL have port mem_addr  out  ADDR_W  address aligned down to DATA_W/8 bytes.
REQ-019 SHALL have ports mem_wen  out  1, mem_wdata  out  DATA_W, and mem_wmask  out  DATA_W/8 (byte-lane strobes).
REQ-020 SHALL have ports mem_rvalid  in  1 (read data or write acknowledge) and mem_rdata  in  DATA_W.

Function
REQ-021 SHALL implement FSM states IDLE, MREQ, MWAIT and RESP; req_ready=1 only in IDLE.
REQ-022 SHALL, in IDLE on req_valid, register wen, funct3, addr and wdata and go to MREQ; when the request is misaligned or illegal it SHALL go to RESP with err=1 and rdata=0, and SHALL issue no memory access.
REQ-023 SHALL treat funct3 000/100 (b/bu), 001/101 (h/hu) and 010 (w) as legal; 110 (wu) and 011 (d) SHALL be legal only when DATA_W=64; all other codes are illegal; stores SHALL accept only 000, 001, 010, and 011 when DATA_W=64.
REQ-024 SHALL flag a request as misaligned when the address is not a multiple of the access size in bytes.
REQ-025 SHALL hold mem_valid=1 with stable mem_* outputs throughout MREQ, and SHALL move to MWAIT on the first cycle with mem_ready=1.
REQ-026 SHALL, for stores, drive mem_wdata as req_wdata replicated or shifted into lanes starting at byte offset addr mod (DATA_W/8), with mem_wmask set only for the accessed lanes; loads SHALL drive mem_wmask=0.
REQ-027 SHALL count MWAIT cycles; on mem_rvalid it SHALL go to RESP with err=0 and, for loads, rdata = the lanes at the offset shifted right then sign-extended (b/h/w) or zero-extended (bu/hu/wu); stores SHALL return rdata=0.
REQ-028 SHALL, when the counter reaches TIMEOUT without mem_rvalid, go to RESP with err=1 and rdata=0, and SHALL ignore a late mem_rvalid.
REQ-029 SHALL, in RESP, hold resp_valid=1 with stable resp_rdata and resp_err until resp_ready=1, then return to IDLE; a new request SHALL be accepted no earlier than the following cycle.
REQ-030 SHALL give a load latency of 3 cycles from acceptance to resp_valid when mem_ready=1 in MREQ and mem_rvalid arrives on the first MWAIT cycle.
REQ-031 SHALL ignore mem_rvalid in every state other than MWAIT.

Reset
REQ-032 SHALL, on rst=0 and independently of clk, force state=IDLE, counter=0, and all outputs to 0 except req_ready=1.
REQ-033 SHALL abort any operation in progress on reset mid-transaction without producing a response; after rst is released the first request SHALL be accepted normally.

Verification
REQ-034 Verification SHALL cover lb at 0x80000003 with mem_rdata=0x80FFFFFF -> mem_addr=0x80000000, mem_wmask=0, resp_rdata=0xFFFFFF80, resp_err=0.
REQ-035 Verification SHALL cover sh at 0x80000002 with wdata=0x0000BEEF -> mem_wdata[31:16]=0xBEEF, mem_wmask=4'b1100, resp_rdata=0.
REQ-036 Verification SHALL cover lw at 0x80000002 -> no mem_valid, resp_err=1 one cycle after acceptance.
REQ-037 Verification SHALL cover a load with TIMEOUT=4 and mem_rvalid never asserted -> resp_err=1 after 4 MWAIT cycles; a later mem_rvalid is ignored.
REQ-038 Verification SHALL cover mem_ready held low for 5 cycles -> mem_* outputs stable for all 5 cycles; resp_ready held low for 3 cycles -> resp_valid and resp_rdata stable for all 3 cycles.
REQ-039 Verification SHALL cover rst pulsed low during MWAIT -> immediate return to IDLE with req_ready=1 and no resp_valid; with DATA_W=64, lwu at offset 4 -> the upper lanes zero-extended.

Source files
------------

// File: rtl/ysyx_24100005_lsu.sv
// ysyx_24100005_lsu: load/store unit between a core request port and a
// single-beat memory port.
//   req_*   : core request (valid/ready), store flag, funct3, byte address,
//             right-aligned store data
//   resp_*  : response (valid/ready), extended load data, error flag
//   mem_*   : memory request (valid/ready) with word-aligned address, lane
//             data and byte strobes; mem_rvalid/mem_rdata return read data or
//             a write acknowledge
// Misaligned or illegal requests are answered with err=1 without touching
// memory. A memory wait longer than TIMEOUT cycles also returns err=1.
module ysyx_24100005_lsu #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wen,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  resp_err,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic                  mem_wen,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_wmask,
  input  logic                  mem_rvalid,
  input  logic [DATA_W-1:0]     mem_rdata
);
  localparam int STRB  = DATA_W / 8;
  localparam int OFF_W = $clog2(STRB);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_MREQ  = 2'd1;
  localparam logic [1:0] S_MWAIT = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              wen_q, wen_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              req_legal, req_misal;
  logic [OFF_W-1:0]  off;
  logic [OFF_W+2:0]  shamt;
  logic [STRB-1:0]   mask_base;
  logic [DATA_W-1:0] ld_sh, ld_ext;

  // Legality depends on direction: loads allow unsigned variants, stores do not.
  always_comb begin
    req_legal = 1'b0;
    if (req_wen) begin
      case (req_funct3)
        3'b000, 3'b001, 3'b010: req_legal = 1'b1;
        3'b011:                 req_legal = (DATA_W == 64);
        default:                req_legal = 1'b0;
      endcase
    end else begin
      case (req_funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: req_legal = 1'b1;
        3'b011, 3'b110:                         req_legal = (DATA_W == 64);
        default:                                req_legal = 1'b0;
      endcase
    end
  end

  // funct3[1:0] is log2 of the access size in bytes.
  always_comb begin
    case (req_funct3[1:0])
      2'd0:    req_misal = 1'b0;
      2'd1:    req_misal = req_addr[0];
      2'd2:    req_misal = |req_addr[1:0];
      default: req_misal = |req_addr[2:0];
    endcase
  end

  assign off   = addr_q[OFF_W-1:0];
  assign shamt = {off, 3'b000};

  always_comb begin
    case (funct3_q[1:0])
      2'd0:    mask_base = STRB'(1);
      2'd1:    mask_base = STRB'(3);
      2'd2:    mask_base = STRB'(15);
      default: mask_base = STRB'(8'hFF);
    endcase
  end

  // Bring the addressed lanes down to bit 0, then extend by funct3.
  always_comb begin
    ld_sh = mem_rdata >> shamt;
    case (funct3_q)
      3'b000:  ld_ext = DATA_W'($signed(ld_sh[7:0]));
      3'b100:  ld_ext = DATA_W'(ld_sh[7:0]);
      3'b001:  ld_ext = DATA_W'($signed(ld_sh[15:0]));
      3'b101:  ld_ext = DATA_W'(ld_sh[15:0]);
      3'b010:  ld_ext = DATA_W'($signed(ld_sh[31:0]));
      3'b110:  ld_ext = DATA_W'(ld_sh[31:0]);
      default: ld_ext = ld_sh;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    wen_d    = wen_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: if (req_valid) begin
        wen_d    = req_wen;
        funct3_d = req_funct3;
        addr_d   = req_addr;
        wdata_d  = req_wdata;
        cnt_d    = '0;
        if (!req_legal || req_misal) begin
          state_d = S_RESP;
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          state_d = S_MREQ;
        end
      end
      S_MREQ: if (mem_ready) begin
        state_d = S_MWAIT;
        cnt_d   = '0;
      end
      S_MWAIT: begin
        if (mem_rvalid) begin
          state_d = S_RESP;
          err_d   = 1'b0;
          rdata_d = wen_q ? '0 : ld_ext;
        end else if (cnt_q == 16'(TIMEOUT - 1)) begin
          state_d = S_RESP;
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_RESP: if (resp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      wen_q    <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wen_q    <= wen_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign mem_valid  = (state_q == S_MREQ);
  assign mem_addr   = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign mem_wen    = mem_valid & wen_q;
  assign mem_wdata  = wdata_q << shamt;
  assign mem_wmask  = (mem_valid && wen_q) ? (mask_base << off) : '0;
  assign resp_valid = (state_q == S_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
endmodule

// File: tb/tb_ysyx_24100005_lsu.sv
// Bench for ysyx_24100005_lsu: a 32-bit and a 64-bit instance share one set
// of stimulus signals; sel picks which one receives requests and whose
// outputs are checked. Expected outputs come from a transaction-level model
// plus a cycle schedule built from the chosen handshake delays.
module tb_ysyx_24100005_lsu;
  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic        req_valid, req_wen, mem_ready, mem_rvalid, resp_ready;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [63:0] req_wdata, mem_rdata;

  logic        a_req_ready, a_resp_valid, a_resp_err, a_mem_valid, a_mem_wen;
  logic [31:0] a_resp_rdata, a_mem_addr, a_mem_wdata;
  logic [3:0]  a_mem_wmask;
  logic        b_req_ready, b_resp_valid, b_resp_err, b_mem_valid, b_mem_wen;
  logic [63:0] b_resp_rdata, b_mem_wdata;
  logic [31:0] b_mem_addr;
  logic [7:0]  b_mem_wmask;

  always #5 clk = ~clk;

  ysyx_24100005_lsu #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(T)) dut32 (
    .clk(clk), .rst(rst), .req_valid(req_valid & ~sel), .req_ready(a_req_ready),
    .req_wen(req_wen), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata[31:0]), .resp_valid(a_resp_valid), .resp_ready(resp_ready),
    .resp_rdata(a_resp_rdata), .resp_err(a_resp_err), .mem_valid(a_mem_valid),
    .mem_ready(mem_ready), .mem_addr(a_mem_addr), .mem_wen(a_mem_wen),
    .mem_wdata(a_mem_wdata), .mem_wmask(a_mem_wmask), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata[31:0]));

  ysyx_24100005_lsu #(.ADDR_W(32), .DATA_W(64), .TIMEOUT(T)) dut64 (
    .clk(clk), .rst(rst), .req_valid(req_valid & sel), .req_ready(b_req_ready),
    .req_wen(req_wen), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(b_resp_valid), .resp_ready(resp_ready),
    .resp_rdata(b_resp_rdata), .resp_err(b_resp_err), .mem_valid(b_mem_valid),
    .mem_ready(mem_ready), .mem_addr(b_mem_addr), .mem_wen(b_mem_wen),
    .mem_wdata(b_mem_wdata), .mem_wmask(b_mem_wmask), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata));

  wire        o_req_ready  = sel ? b_req_ready  : a_req_ready;
  wire        o_mem_valid  = sel ? b_mem_valid  : a_mem_valid;
  wire        o_resp_valid = sel ? b_resp_valid : a_resp_valid;
  wire        o_resp_err   = sel ? b_resp_err   : a_resp_err;
  wire        o_mem_wen    = sel ? b_mem_wen    : a_mem_wen;
  wire [31:0] o_mem_addr   = sel ? b_mem_addr   : a_mem_addr;
  wire [7:0]  o_mem_wmask  = sel ? b_mem_wmask  : {4'b0, a_mem_wmask};
  wire [63:0] o_mem_wdata  = sel ? b_mem_wdata  : {32'b0, a_mem_wdata};
  wire [63:0] o_resp_rdata = sel ? b_resp_rdata : {32'b0, a_resp_rdata};

  int checks = 0, errors = 0;
  bit chk_en = 1'b0;
  logic        e_req_ready, e_mem_valid, e_resp_valid, e_mem_wen, e_resp_err;
  logic [31:0] e_mem_addr;
  logic [7:0]  e_mem_wmask;
  logic [63:0] e_mem_wdata, e_resp_rdata;
  logic [63:0] last_rdata, last_wdata;
  logic [31:0] last_addr;
  logic [7:0]  last_wmask;
  logic        last_err;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s sel=%0d t=%0t act=%h exp=%h", nm, sel, $time, act, exp);
    end
  endtask

  function automatic logic [63:0] lane_bits(input logic [7:0] mk);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = {8{mk[i]}};
    return r;
  endfunction

  // Transaction-level model: what the memory request and the response must be.
  function automatic void model(input int dw, input logic wen, input logic [2:0] f3,
      input logic [31:0] a, input logic [63:0] wd, input logic [63:0] rin,
      output bit bad, output logic [31:0] ma, output logic [7:0] mk,
      output logic [63:0] mwd, output logic [63:0] rd);
    int sz, nb, off;
    bit legal;
    logic [63:0] dmask, v, lim;
    sz = 1 << f3[1:0];
    nb = dw / 8;
    off = int'(a % nb);
    dmask = (dw == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    if (wen) legal = (f3 <= 3'd2) || (f3 == 3'd3 && dw == 64);
    else     legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) ||
                     ((f3 == 3'd3 || f3 == 3'd6) && dw == 64);
    bad = !legal || (a % sz != 0);
    ma  = a - off;
    mk  = wen ? 8'(((1 << sz) - 1) << off) : 8'h00;
    mwd = (wd << (8 * off)) & dmask;
    rd  = '0;
    if (!wen && !bad) begin
      lim = (sz == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * sz)) - 64'd1);
      v = ((rin & dmask) >> (8 * off)) & lim;
      if (!f3[2] && sz < 8 && v[8*sz-1]) v = v | ~lim;
      rd = v & dmask;
    end
  endfunction

  always @(negedge clk) if (chk_en) begin
    chk("req_ready", 64'(o_req_ready), 64'(e_req_ready));
    chk("mem_valid", 64'(o_mem_valid), 64'(e_mem_valid));
    chk("resp_valid", 64'(o_resp_valid), 64'(e_resp_valid));
    if (e_mem_valid) begin
      chk("mem_addr", 64'(o_mem_addr), 64'(e_mem_addr));
      chk("mem_wen", 64'(o_mem_wen), 64'(e_mem_wen));
      chk("mem_wmask", 64'(o_mem_wmask), 64'(e_mem_wmask));
      chk("mem_wdata", o_mem_wdata & lane_bits(e_mem_wmask), e_mem_wdata & lane_bits(e_mem_wmask));
    end
    if (e_resp_valid) begin
      chk("resp_rdata", o_resp_rdata, e_resp_rdata);
      chk("resp_err", 64'(o_resp_err), 64'(e_resp_err));
    end
    if (o_mem_valid) begin
      last_addr = o_mem_addr; last_wmask = o_mem_wmask; last_wdata = o_mem_wdata;
    end
    if (o_resp_valid) begin
      last_rdata = o_resp_rdata; last_err = o_resp_err;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic exp_state(input logic rr, input logic mv, input logic rv);
    e_req_ready = rr; e_mem_valid = mv; e_resp_valid = rv;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      exp_state(1, 0, 0);
      req_valid = 0; mem_ready = 1'($urandom); mem_rvalid = 1'($urandom);
      resp_ready = 1'($urandom); mem_rdata = {$urandom, $urandom};
      step();
    end
  endtask

  task automatic txn(input bit s, input logic wen, input logic [2:0] f3,
      input logic [31:0] a, input logic [63:0] wd, input logic [63:0] rin,
      input int d1, input int d2, input int d3);
    bit bad, tmo;
    logic [31:0] ma; logic [7:0] mk; logic [63:0] mwd, rd;
    int n;
    sel = s;
    model(s ? 64 : 32, wen, f3, a, wd, rin, bad, ma, mk, mwd, rd);
    exp_state(1, 0, 0);
    req_valid = 1; req_wen = wen; req_funct3 = f3; req_addr = a; req_wdata = wd;
    mem_ready = 1'($urandom); mem_rvalid = 1'($urandom); resp_ready = 1'($urandom);
    step();
    req_valid = 0; req_wen = 1'($urandom); req_funct3 = 3'($urandom);
    req_addr = $urandom; req_wdata = {$urandom, $urandom};
    tmo = 0;
    if (!bad) begin
      e_mem_addr = ma; e_mem_wen = wen; e_mem_wmask = mk; e_mem_wdata = mwd;
      for (int i = 0; i <= d1; i++) begin
        exp_state(0, 1, 0);
        mem_ready = (i == d1); mem_rvalid = 1'($urandom); mem_rdata = {$urandom, $urandom};
        step();
      end
      tmo = (d2 >= T);
      n = tmo ? T : d2 + 1;
      for (int i = 0; i < n; i++) begin
        exp_state(0, 0, 0);
        mem_ready = 1'($urandom); mem_rvalid = (i == d2);
        mem_rdata = (i == d2) ? rin : {$urandom, $urandom};
        step();
      end
    end
    e_resp_err = bad || tmo;
    e_resp_rdata = (bad || tmo) ? 64'd0 : rd;
    for (int i = 0; i <= d3; i++) begin
      exp_state(0, 0, 1);
      resp_ready = (i == d3); mem_ready = 1'($urandom);
      mem_rvalid = (i == 0 && tmo) ? 1'b1 : 1'($urandom);
      mem_rdata = {$urandom, $urandom};
      step();
    end
    exp_state(1, 0, 0);
    resp_ready = 0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] f3; logic [31:0] a; int sz;
    rst = 0; sel = 0; req_valid = 0; req_wen = 0; req_funct3 = 0; req_addr = 0;
    req_wdata = 0; mem_ready = 0; mem_rvalid = 0; mem_rdata = 0; resp_ready = 0;
    #3;
    chk("rst_req_ready32", 64'(a_req_ready), 64'd1);
    chk("rst_req_ready64", 64'(b_req_ready), 64'd1);
    chk("rst_outs32", {a_resp_valid, a_resp_err, a_mem_valid, a_mem_wen, a_mem_wmask, a_resp_rdata}, 64'd0);
    chk("rst_outs64", 64'({b_resp_valid, b_resp_err, b_mem_valid, b_mem_wen, b_mem_wmask}), 64'd0);
    chk("rst_rdata64", b_resp_rdata, 64'd0);
    step(); rst = 1;
    exp_state(1, 0, 0); chk_en = 1;
    idle(2);

    // lb with sign extension, minimum latency
    txn(0, 0, 3'b000, 32'h8000_0003, 64'd0, 64'h80FF_FFFF, 0, 0, 0);
    chk("pin_lb_addr", 64'(last_addr), 64'h8000_0000);
    chk("pin_lb_wmask", 64'(last_wmask), 64'd0);
    chk("pin_lb_rdata", last_rdata, 64'hFFFF_FF80);
    chk("pin_lb_err", 64'(last_err), 64'd0);
    // sh into upper half
    txn(0, 1, 3'b001, 32'h8000_0002, 64'h0000_BEEF, 64'd0, 0, 1, 0);
    chk("pin_sh_wdata", 64'(last_wdata[31:16]), 64'hBEEF);
    chk("pin_sh_wmask", 64'(last_wmask), 64'b1100);
    chk("pin_sh_rdata", last_rdata, 64'd0);
    // misaligned lw
    txn(0, 0, 3'b010, 32'h8000_0002, 64'd0, 64'd0, 0, 0, 0);
    chk("pin_mis_err", 64'(last_err), 64'd1);
    // timeout, late rvalid ignored
    txn(0, 0, 3'b010, 32'h8000_0008, 64'd0, 64'h1234_5678, 0, 9, 1);
    chk("pin_tmo_err", 64'(last_err), 64'd1);
    chk("pin_tmo_rdata", last_rdata, 64'd0);
    idle(2);
    // stalls on both handshakes
    txn(0, 0, 3'b010, 32'h8000_0010, 64'd0, 64'hCAFE_F00D, 5, 2, 3);
    // wu illegal on 32-bit
    txn(0, 0, 3'b110, 32'h8000_0004, 64'd0, 64'd0, 0, 0, 0);

    // reset pulsed in MWAIT
    sel = 0; exp_state(1, 0, 0);
    req_valid = 1; req_wen = 0; req_funct3 = 3'b010; req_addr = 32'h8000_0020;
    mem_rvalid = 0; mem_ready = 1; resp_ready = 1;
    step();
    req_valid = 0; exp_state(0, 1, 0); e_mem_addr = 32'h8000_0020; e_mem_wen = 0;
    e_mem_wmask = 0; e_mem_wdata = 0;
    step();
    exp_state(0, 0, 0); mem_rvalid = 0;
    #1;
    chk("rstmid_busy", 64'(o_req_ready), 64'd0);
    rst = 0; exp_state(1, 0, 0);
    #1;
    chk("rstmid_req_ready", 64'(o_req_ready), 64'd1);
    chk("rstmid_resp_valid", 64'(o_resp_valid), 64'd0);
    chk("rstmid_mem_valid", 64'(o_mem_valid), 64'd0);
    mem_rvalid = 1;
    step(); rst = 1;
    idle(2);
    txn(0, 0, 3'b100, 32'h8000_0021, 64'd0, 64'h0000_9900, 1, 1, 0);
    chk("pin_after_rst", last_rdata, 64'h99);

    // 64-bit instance
    txn(1, 0, 3'b110, 32'h8000_0004, 64'd0, 64'h89AB_CDEF_0123_4567, 0, 0, 0);
    chk("pin_lwu64", last_rdata, 64'h0000_0000_89AB_CDEF);
    txn(1, 0, 3'b010, 32'h8000_0004, 64'd0, 64'h89AB_CDEF_0123_4567, 0, 0, 0);
    chk("pin_lw64", last_rdata, 64'hFFFF_FFFF_89AB_CDEF);
    txn(1, 1, 3'b011, 32'h8000_0008, 64'h1122_3344_5566_7788, 64'd0, 1, 0, 0);
    chk("pin_sd64_wmask", 64'(last_wmask), 64'hFF);

    for (int k = 0; k < 400; k++) begin
      f3 = 3'($urandom_range(0, 7));
      sz = 1 << f3[1:0];
      a = 32'h8000_0000 | $urandom_range(0, 63);
      if ($urandom_range(0, 3) != 0) a = a & ~(sz - 1);
      txn(1'($urandom), 1'($urandom), f3, a, {$urandom, $urandom}, {$urandom, $urandom},
          $urandom_range(0, 3),
          ($urandom_range(0, 9) < 8) ? $urandom_range(0, T - 1) : $urandom_range(T, T + 2),
          $urandom_range(0, 2));
      idle($urandom_range(0, 1));
    end

    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
